// File: rtl/oam_write_ctrl.sv
// oam_write_ctrl: buffers S-type sprite-attribute writes from the decode stage
// in a small FIFO and drains them into OAM RAM only while the PPU is not
// reading OAM. Back-pressures the pipeline with oam_stall.
// Optional feature macro: OAM_CLEAR_EN (adds the CLEAR state that walks all
// 64 OAM entries writing an off-screen y-coordinate).
module oam_write_ctrl #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3,
  parameter logic [7:0]  CLEAR_Y    = 8'hF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oam_wr,
  input  logic [9:0]       S_type_index,
  input  logic [31:0]      S_type_value,
  input  logic             ppu_busy,
  input  logic             clear_req,
  output logic             oam_stall,
  output logic             oam_we,
  output logic [5:0]       oam_addr,
  output logic [31:0]      oam_wdata,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

`ifdef OAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAIN} state_t;
`endif

  state_t             state, state_nxt;
  logic [5:0]         buf_addr [FIFO_DEPTH];
  logic [31:0]        buf_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, empty, push, pop;

`ifdef OAM_CLEAR_EN
  logic [5:0]         clr_addr;
  logic               clr_pending;
  logic               clr_step;
`else
  logic               unused_ok;
  assign unused_ok = ^{S_type_index[9:6], clear_req, CLEAR_Y};
`endif

  assign fifo_count = count;

  // Handshake and next-state decode; stall depends only on state and count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    full      = (count == CNT_W'(FIFO_DEPTH));
    empty     = (count == '0);
`ifdef OAM_CLEAR_EN
    oam_stall = full || (state == CLEAR);
    clr_step  = (state == CLEAR) && !ppu_busy;
`else
    oam_stall = full;
`endif
    push      = oam_wr && !oam_stall;
    pop       = (state == DRAIN) && !empty && !ppu_busy;

    case (state)
      IDLE: begin
        // Entering DRAIN on the accepting edge lets the first pop happen one edge later.
        if (!empty || push) state_nxt = DRAIN;
`ifdef OAM_CLEAR_EN
        else if (clear_req || clr_pending) state_nxt = CLEAR;
`endif
      end
      DRAIN: begin
        // Stay until the FIFO is empty and the last registered write has landed.
        if (empty && !push && !oam_we) state_nxt = IDLE;
      end
`ifdef OAM_CLEAR_EN
      CLEAR: begin
        if (clr_step && (clr_addr == 6'd63)) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage write port; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    // NOTE: the buffer array is deliberately not reset; occupancy lives in count/pointers.
    if (push) begin
      buf_addr[wr_ptr] <= S_type_index[5:0];
      buf_data[wr_ptr] <= S_type_value;
    end
  end

  // State register, FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef OAM_CLEAR_EN
  // Clear walk address and the pending flag for a clear requested mid-drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr    <= '0;
      clr_pending <= 1'b0;
    end else begin
      if (clr_step) clr_addr <= clr_addr + 6'd1;
      if ((state_nxt == CLEAR) && (state != CLEAR)) clr_pending <= 1'b0;
      else if (clear_req && (state != CLEAR))      clr_pending <= 1'b1;
    end
  end
`endif

  // Registered OAM write port: a FIFO pop or a clear step drives one strobe next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      oam_we    <= 1'b0;
      oam_addr  <= '0;
      oam_wdata <= '0;
    end else begin
      oam_we <= 1'b0;
      if (pop) begin
        oam_we    <= 1'b1;
        oam_addr  <= buf_addr[rd_ptr];
        oam_wdata <= buf_data[rd_ptr];
      end
`ifdef OAM_CLEAR_EN
      else if (clr_step) begin
        oam_we    <= 1'b1;
        oam_addr  <= clr_addr;
        oam_wdata <= {24'h000000, CLEAR_Y};
      end
`endif
    end
  end

endmodule

// File: tb/tb_oam_write_ctrl.sv
// Self-checking bench for oam_write_ctrl: accepted writes are pushed to a
// scoreboard queue and compared in order against each OAM write strobe.
module tb_oam_write_ctrl;

  logic        clk = 1'b0;
  logic        rst, oam_wr, ppu_busy, clear_req;
  logic [9:0]  S_type_index;
  logic [31:0] S_type_value;
  logic        oam_stall, oam_we;
  logic [5:0]  oam_addr;
  logic [31:0] oam_wdata;
  logic [2:0]  fifo_count;

  int          errors = 0;
  int          checks = 0;
  logic [37:0] sb_q [$];
  logic [37:0] sb_exp;
  bit          sb_off = 1'b0;

  oam_write_ctrl #(.FIFO_DEPTH(4), .CNT_W(3), .CLEAR_Y(8'hF0)) dut (
    .clk(clk), .rst(rst), .oam_wr(oam_wr), .S_type_index(S_type_index),
    .S_type_value(S_type_value), .ppu_busy(ppu_busy), .clear_req(clear_req),
    .oam_stall(oam_stall), .oam_we(oam_we), .oam_addr(oam_addr),
    .oam_wdata(oam_wdata), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: compare every OAM write against the oldest accepted request,
  // then record any request that the coming edge will accept.
  always @(negedge clk) begin
    if (oam_we && !sb_off) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%h, expected no write", oam_addr, oam_wdata);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({oam_addr, oam_wdata} !== sb_exp) begin
          errors++;
          $display("FAIL sb_order: got addr=%0d data=%h, expected addr=%0d data=%h",
                   oam_addr, oam_wdata, sb_exp[37:32], sb_exp[31:0]);
        end
      end
    end
    if (oam_wr && !oam_stall && !rst) sb_q.push_back({S_type_index[5:0], S_type_value});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [9:0] idx, input logic [31:0] val);
    oam_wr       = 1'b1;
    S_type_index = idx;
    S_type_value = val;
  endtask

  // Waits for the scoreboard and FIFO to empty, then lets the FSM settle to IDLE.
  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || fifo_count != 0 || oam_we) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending entries, expected 0", name, sb_q.size());
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; oam_wr = 1'b0; ppu_busy = 1'b0; clear_req = 1'b0;
    S_type_index = '0; S_type_value = '0;
    tick(); tick();
    checks += 5;
    if (oam_we !== 1'b0)     begin errors++; $display("FAIL reset_we: got %b expected 0", oam_we); end
    if (oam_addr !== 6'd0)   begin errors++; $display("FAIL reset_addr: got %0d expected 0", oam_addr); end
    if (oam_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", oam_wdata); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    if (oam_stall !== 1'b0)  begin errors++; $display("FAIL reset_stall: got %b expected 0", oam_stall); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    set_wr(10'd5, 32'h40_12_03_80);
    tick();                       // accepted here
    oam_wr = 1'b0;
    checks += 2;
    if (oam_we !== 1'b0)     begin errors++; $display("FAIL single_we_early: got %b expected 0", oam_we); end
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d expected 1", fifo_count); end
    tick();                       // pop decision here
    checks += 4;
    if (oam_we !== 1'b1)            begin errors++; $display("FAIL single_we: got %b expected 1", oam_we); end
    if (oam_addr !== 6'd5)          begin errors++; $display("FAIL single_addr: got %0d expected 5", oam_addr); end
    if (oam_wdata !== 32'h40120380) begin errors++; $display("FAIL single_wdata: got %h expected 40120380", oam_wdata); end
    if (fifo_count !== 3'd0)        begin errors++; $display("FAIL single_count0: got %0d expected 0", fifo_count); end
    tick();
    checks++;
    if (oam_we !== 1'b0) begin errors++; $display("FAIL single_we_once: got %b expected 0", oam_we); end
    wait_drain("single");
  endtask

  task automatic test_backpressure();
    ppu_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_wr(10'(8 + i), 32'hA000_0000 | 32'(i));
      tick();
    end
    set_wr(10'd12, 32'hA000_0004);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 3;
      if (oam_stall !== 1'b1)  begin errors++; $display("FAIL bp_stall_full: got %b expected 1", oam_stall); end
      if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count_full: got %0d expected 4", fifo_count); end
      if (oam_we !== 1'b0)     begin errors++; $display("FAIL bp_we_busy: got %b expected 0", oam_we); end
    end
    ppu_busy = 1'b0;
    tick();                       // pop with a stalled push at count=4
    checks += 3;
    if (fifo_count !== 3'd3) begin errors++; $display("FAIL bp_full_push_rejected: got count %0d expected 3", fifo_count); end
    if (oam_stall !== 1'b0)  begin errors++; $display("FAIL bp_stall_release: got %b expected 0", oam_stall); end
    if (oam_we !== 1'b1)     begin errors++; $display("FAIL bp_first_we: got %b expected 1", oam_we); end
    tick();                       // retried push accepted alongside a pop
    oam_wr = 1'b0;
    checks += 2;
    if (fifo_count !== 3'd3) begin errors++; $display("FAIL bp_retry_count: got %0d expected 3", fifo_count); end
    if (oam_we !== 1'b1)     begin errors++; $display("FAIL bp_we_2: got %b expected 1", oam_we); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (oam_we !== 1'b1) begin errors++; $display("FAIL bp_we_consecutive: cycle %0d got %b expected 1", i, oam_we); end
    end
    tick();
    checks++;
    if (oam_we !== 1'b0) begin errors++; $display("FAIL bp_we_after: got %b expected 0", oam_we); end
    wait_drain("bp");
  endtask

  task automatic test_push_pop_same_edge();
    ppu_busy = 1'b1;
    set_wr(10'd30, 32'h1111_1111); tick();
    set_wr(10'd31, 32'h2222_2222); tick();
    set_wr(10'd32, 32'h3333_3333);
    ppu_busy = 1'b0;
    tick();
    oam_wr = 1'b0;
    checks += 2;
    if (fifo_count !== 3'd2) begin errors++; $display("FAIL pushpop_count: got %0d expected 2", fifo_count); end
    if (oam_we !== 1'b1)     begin errors++; $display("FAIL pushpop_we: got %b expected 1", oam_we); end
    wait_drain("pushpop");
  endtask

  task automatic test_toggle_busy();
    int  rem = 4;
    bit  busy_now, exp_we;
    ppu_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_wr(10'(40 + i), 32'hC0DE_0000 | 32'(i));
      tick();
    end
    oam_wr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      busy_now = (k % 2) == 1;
      ppu_busy = busy_now;
      tick();
      exp_we = !busy_now && rem > 0;
      if (exp_we) rem--;
      checks++;
      if (oam_we !== exp_we) begin errors++; $display("FAIL toggle_we: step %0d got %b expected %b", k, oam_we, exp_we); end
    end
    ppu_busy = 1'b0;
    wait_drain("toggle");
  endtask

  task automatic test_reset_mid_drain();
    bit any_we = 1'b0;
    ppu_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_wr(10'(50 + i), 32'hDEAD_0000 | 32'(i));
      tick();
    end
    oam_wr = 1'b0;
    ppu_busy = 1'b0;
    rst = 1'b1;
    tick();
    sb_q.delete();
    checks += 3;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_drain_count: got %0d expected 0", fifo_count); end
    if (oam_we !== 1'b0)     begin errors++; $display("FAIL rst_drain_we: got %b expected 0", oam_we); end
    if (oam_stall !== 1'b0)  begin errors++; $display("FAIL rst_drain_stall: got %b expected 0", oam_stall); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (oam_we) any_we = 1'b1;
    end
    checks++;
    if (any_we !== 1'b0) begin errors++; $display("FAIL rst_drain_discard: got write after reset, expected none"); end
  endtask

  task automatic test_back_to_back();
    ppu_busy = 1'b0;
    set_wr(10'h3C7, 32'h0101_0101); tick();
    set_wr(10'h007, 32'h0202_0202); tick();
    checks++;
    if (oam_we !== 1'b1) begin errors++; $display("FAIL b2b_we_1: got %b expected 1", oam_we); end
    set_wr(10'h015, 32'h0303_0303); tick();
    oam_wr = 1'b0;
    checks++;
    if (oam_we !== 1'b1) begin errors++; $display("FAIL b2b_we_2: got %b expected 1", oam_we); end
    tick();
    checks++;
    if (oam_we !== 1'b1 || oam_addr !== 6'd21) begin
      errors++; $display("FAIL b2b_we_3: got we=%b addr=%0d expected we=1 addr=21", oam_we, oam_addr);
    end
    tick();
    checks++;
    if (oam_we !== 1'b0) begin errors++; $display("FAIL b2b_we_end: got %b expected 0", oam_we); end
    wait_drain("b2b");
  endtask

`ifdef OAM_CLEAR_EN
  task automatic test_clear();
    int seen = 0;
    int cyc  = 0;
    sb_off = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    while (seen < 64 && cyc < 300) begin
      ppu_busy = (cyc >= 25 && cyc < 28);
      tick();
      cyc++;
      if (!(oam_we && oam_addr == 6'd63)) begin
        checks++;
        if (oam_stall !== 1'b1) begin errors++; $display("FAIL clear_stall: cycle %0d got %b expected 1", cyc, oam_stall); end
      end
      if (oam_we) begin
        checks++;
        if (oam_addr !== 6'(seen) || oam_wdata !== 32'h000000F0) begin
          errors++;
          $display("FAIL clear_write: got addr=%0d data=%h expected addr=%0d data=000000f0", oam_addr, oam_wdata, seen);
        end
        seen++;
      end
    end
    ppu_busy = 1'b0;
    checks++;
    if (seen != 64) begin errors++; $display("FAIL clear_count: got %0d writes expected 64", seen); end
    tick();
    checks += 2;
    if (oam_we !== 1'b0)    begin errors++; $display("FAIL clear_done_we: got %b expected 0", oam_we); end
    if (oam_stall !== 1'b0) begin errors++; $display("FAIL clear_done_stall: got %b expected 0", oam_stall); end
    sb_off = 1'b0;
  endtask

  task automatic test_clear_reset();
    int  cyc = 0;
    bit  hit = 1'b0;
    sb_off = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    while (!hit && cyc < 200) begin
      tick();
      cyc++;
      if (oam_we && oam_addr == 6'd20) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL clear_rst_reach: got no write to addr 20, expected one"); end
    rst = 1'b1;
    tick();
    checks += 2;
    if (oam_we !== 1'b0)    begin errors++; $display("FAIL clear_rst_we: got %b expected 0", oam_we); end
    if (oam_stall !== 1'b0) begin errors++; $display("FAIL clear_rst_stall: got %b expected 0", oam_stall); end
    rst = 1'b0;
    tick();
    checks += 2;
    if (oam_we !== 1'b0)    begin errors++; $display("FAIL clear_rst_idle_we: got %b expected 0", oam_we); end
    if (oam_stall !== 1'b0) begin errors++; $display("FAIL clear_rst_idle_stall: got %b expected 0", oam_stall); end
    sb_off = 1'b0;
  endtask
`else
  task automatic test_clear_ignored();
    bit any = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (oam_we || oam_stall) any = 1'b1;
    end
    checks++;
    if (any !== 1'b0) begin errors++; $display("FAIL clear_ignored: got write or stall, expected neither"); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_push_pop_same_edge();
    test_toggle_busy();
    test_reset_mid_drain();
    test_back_to_back();
`ifdef OAM_CLEAR_EN
    test_clear();
    test_clear_reset();
`else
    test_clear_ignored();
`endif
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
